// File: rtl/mem_if_pkg.sv
// Shared types and default memory window for the latency-modelled memory responder.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [63:0] MEM_BASE_DEF = 64'h0000_0000_8000_0000;
    localparam logic [63:0] MEM_SIZE_DEF = 64'h0000_0000_0800_0000;

    typedef struct packed {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    function automatic logic in_window(input logic [63:0] addr, input logic [63:0] base,
                                       input logic [63:0] size);
        return (addr >= base) && (addr < base + size);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response channels between core and responder, plus the memory access port.
interface mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    // One-cycle strobes standing in for the simulator's vmem read/write calls
    logic        mem_rd;
    logic        mem_wr;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_rd, mem_wr, mem_addr, mem_wdata, mem_wmask
    );

    modport memory (
        input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_wmask,
        output mem_rdata
    );

endinterface

// File: rtl/mem_lat_counter.sv
// 8-bit latency counter: load, decrement towards zero, zero flag.
module mem_lat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [7:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != 8'd0)) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accept, wait LATENCY cycles, access, respond.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned LATENCY  = 2,
    parameter logic [63:0] MEM_BASE = MEM_BASE_DEF,
    parameter logic [63:0] MEM_SIZE = MEM_SIZE_DEF
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam logic [7:0] LOAD_VAL = 8'(LATENCY - 1);

    state_e      state_q, state_d;
    req_t        req_q;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        accept, access, in_range, zero;

    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign access        = (state_q == WAIT) && zero;
    assign in_range      = in_window(req_q.addr, MEM_BASE, MEM_SIZE);

    mem_lat_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (LOAD_VAL),
        .dec      (state_q == WAIT),
        .zero     (zero)
    );

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: if (accept) state_d = WAIT;
            WAIT: begin
                if (zero) begin
                    state_d = RESP;
                    err_d   = !in_range;
                    rdata_d = (!req_q.wen && in_range) ? bus.mem_rdata : 64'd0;
                end
            end
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                req_q.addr  <= bus.req_addr;
                req_q.wen   <= bus.req_wen;
                req_q.wdata <= bus.req_wdata;
                req_q.wmask <= bus.req_wmask;
            end
        end
    end

    // Access strobes fire only on the access edge, so a reset during WAIT suppresses them
    assign bus.mem_rd    = access && !req_q.wen && in_range;
    assign bus.mem_wr    = access && req_q.wen && in_range;
    assign bus.mem_addr  = {req_q.addr[63:3], 3'b000};
    assign bus.mem_wdata = req_q.wdata;
    assign bus.mem_wmask = req_q.wmask;

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: vector table through a response scoreboard plus corner sequences.
module tb_mem_responder;
    import mem_if_pkg::*;

    localparam int unsigned LAT = 2;
    localparam logic [63:0] TOP_WORD = 64'h1122_3344_5566_7788;
    localparam logic [63:0] MEM4_INIT = 64'h5555_AAAA_5555_AAAA;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst4 = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if bus ();
    mem_responder_if bus4 ();

    mem_responder #(.LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
    mem_responder #(.LATENCY(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));

    // Memory model for the main DUT: 16 doublewords at MEM_BASE plus the last valid doubleword
    logic [63:0] mem_a [16];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = 4'd0;
    logic [63:0] pl_data = 64'd0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;

    always_comb begin
        if (bus.mem_addr[63:7] == 57'h100_0000) bus.mem_rdata = mem_a[bus.mem_addr[6:3]];
        else if (bus.mem_addr == 64'h87FF_FFF8) bus.mem_rdata = TOP_WORD;
        else bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    end

    always @(posedge clk) begin
        if (pl_en) mem_a[pl_idx] <= pl_data;
        if (bus.mem_rd) rd_cnt <= rd_cnt + 1;
        if (bus.mem_wr) begin
            wr_cnt <= wr_cnt + 1;
            for (int b = 0; b < 8; b++)
                if (bus.mem_wmask[b]) mem_a[bus.mem_addr[6:3]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
    end

    // Single-word memory for the LATENCY=4 instance
    logic [63:0] mem4 = MEM4_INIT;
    int          wr4 = 0;
    assign bus4.mem_rdata = mem4;
    always @(posedge clk) begin
        if (bus4.mem_wr) begin
            wr4 <= wr4 + 1;
            for (int b = 0; b < 8; b++)
                if (bus4.mem_wmask[b]) mem4[8*b +: 8] <= bus4.mem_wdata[8*b +: 8];
        end
    end

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] exp_rdata;
        logic        exp_err;
        int          exp_calls;
    } vec_t;

    rsp_t exp_q[$];
    vec_t vecs[11];
    int   checks = 0;
    int   errors = 0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request at a negedge, hold through the accept edge, then scramble the inputs
    task automatic issue(input logic [63:0] a, input logic w, input logic [63:0] d,
                         input logic [7:0] m);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_wen   = w;
        bus.req_wdata = d;
        bus.req_wmask = m;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = ~a;
        bus.req_wen   = ~w;
        bus.req_wdata = ~d;
        bus.req_wmask = ~m;
    endtask

    task automatic wait_rsp(output int cyc);
        @(negedge clk);
        cyc = 0;
        while (!bus.rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   cyc;
        int   calls0;
        rsp_t e;
        calls0 = rd_cnt + wr_cnt;
        @(negedge clk);
        check64({tag, " req_ready"}, 64'(bus.req_ready), 64'd1);
        issue(v.addr, v.wen, v.wdata, v.wmask);
        exp_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        wait_rsp(cyc);
        check64({tag, " latency"}, 64'(cyc), 64'(LAT));
        e = exp_q.pop_front();
        if (bus.rsp_valid) begin
            check64({tag, " rdata"}, bus.rsp_rdata, e.rdata);
            check64({tag, " err"}, 64'(bus.rsp_err), 64'(e.err));
            check64({tag, " mem calls"}, 64'(rd_cnt + wr_cnt - calls0), 64'(v.exp_calls));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   cyc;
        int   calls0;
        rsp_t e;

        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wen = 1'b0;
        bus.req_wdata = '0; bus.req_wmask = '0; bus.rsp_ready = 1'b1;
        bus4.req_valid = 1'b0; bus4.req_addr = '0; bus4.req_wen = 1'b0;
        bus4.req_wdata = '0; bus4.req_wmask = '0; bus4.rsp_ready = 1'b1;

        vecs[0]  = '{64'h8000_0000, 1'b0, 64'd0, 8'h00, 64'h0010_0093_0000_0013, 1'b0, 1};
        vecs[1]  = '{64'h8000_0008, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 64'd0, 1'b0, 1};
        vecs[2]  = '{64'h8000_0008, 1'b0, 64'd0, 8'h00, 64'h0000_0000_CAFE_F00D, 1'b0, 1};
        vecs[3]  = '{64'h7FFF_FFF8, 1'b0, 64'd0, 8'h00, 64'd0, 1'b1, 0};
        vecs[4]  = '{64'h8800_0000, 1'b0, 64'd0, 8'h00, 64'd0, 1'b1, 0};
        vecs[5]  = '{64'h87FF_FFF8, 1'b0, 64'd0, 8'h00, TOP_WORD, 1'b0, 1};
        vecs[6]  = '{64'h8000_0008, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'd0, 1'b0, 1};
        vecs[7]  = '{64'h8000_0008, 1'b0, 64'd0, 8'h00, 64'h0000_0000_CAFE_F00D, 1'b0, 1};
        vecs[8]  = '{64'h8000_0010, 1'b1, 64'hAABB_CCDD_1122_3344, 8'hF0, 64'd0, 1'b0, 1};
        vecs[9]  = '{64'h8000_0013, 1'b0, 64'd0, 8'h00, 64'hAABB_CCDD_0000_0000, 1'b0, 1};
        vecs[10] = '{64'h8800_0000, 1'b1, 64'h1234, 8'hFF, 64'd0, 1'b1, 0};

        // Reset state and memory preload
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pl_en   = 1'b1;
            pl_idx  = 4'(i);
            pl_data = (i == 0) ? 64'h0010_0093_0000_0013 : 64'd0;
        end
        @(negedge clk);
        pl_en = 1'b0;
        check64("reset req_ready", 64'(bus.req_ready), 64'd0);
        check64("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check64("reset rsp_rdata", bus.rsp_rdata, 64'd0);
        check64("reset rsp_err", 64'(bus.rsp_err), 64'd0);
        rst = 1'b0;
        rst4 = 1'b0;
        @(negedge clk);
        check64("post-reset req_ready", 64'(bus.req_ready), 64'd1);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: response held stable, single memory read
        bus.rsp_ready = 1'b0;
        calls0 = rd_cnt;
        issue(64'h8000_0000, 1'b0, 64'd0, 8'h00);
        exp_q.push_back('{rdata: 64'h0010_0093_0000_0013, err: 1'b0});
        wait_rsp(cyc);
        check64("bp latency", 64'(cyc), 64'(LAT));
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check64("bp rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check64("bp rdata", bus.rsp_rdata, e.rdata);
            check64("bp req_ready", 64'(bus.req_ready), 64'd0);
        end
        check64("bp read calls", 64'(rd_cnt - calls0), 64'd1);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check64("bp released rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check64("bp released req_ready", 64'(bus.req_ready), 64'd1);

        // Mid-cycle reset while in RESP drops the response
        bus.rsp_ready = 1'b0;
        issue(64'h8000_0008, 1'b0, 64'd0, 8'h00);
        exp_q.push_back('{rdata: 64'h0000_0000_CAFE_F00D, err: 1'b0});
        wait_rsp(cyc);
        check64("rst-resp rsp_valid before", 64'(bus.rsp_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check64("rst-resp rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check64("rst-resp req_ready", 64'(bus.req_ready), 64'd0);
        check64("rst-resp rsp_rdata", bus.rsp_rdata, 64'd0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check64("rst-resp req_ready after", 64'(bus.req_ready), 64'd1);
        check64("rst-resp rsp_valid after", 64'(bus.rsp_valid), 64'd0);

        // LATENCY=4: reset in WAIT with cnt=2 suppresses the write
        @(negedge clk);
        bus4.req_valid = 1'b1; bus4.req_addr = 64'h8000_0010; bus4.req_wen = 1'b1;
        bus4.req_wdata = 64'h1111_2222_3333_4444; bus4.req_wmask = 8'hFF;
        @(posedge clk);
        #1 bus4.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst4 = 1'b1;
        #1;
        check64("l4 rst rsp_valid", 64'(bus4.rsp_valid), 64'd0);
        check64("l4 rst req_ready", 64'(bus4.req_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst4 = 1'b0;
        repeat (6) @(negedge clk);
        check64("l4 rst write count", 64'(wr4), 64'd0);
        check64("l4 rst mem", mem4, MEM4_INIT);
        check64("l4 rst idle", 64'(bus4.req_ready), 64'd1);
        check64("l4 rst no rsp", 64'(bus4.rsp_valid), 64'd0);

        // LATENCY=4: completed masked write
        bus4.req_valid = 1'b1; bus4.req_wmask = 8'h3C;
        @(posedge clk);
        #1 bus4.req_valid = 1'b0;
        @(negedge clk);
        cyc = 0;
        while (!bus4.rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check64("l4 latency", 64'(cyc), 64'd4);
        check64("l4 write count", 64'(wr4), 64'd1);
        check64("l4 mem", mem4, 64'h5555_2222_3333_AAAA);
        check64("l4 rdata", bus4.rsp_rdata, 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check64("l4 back to idle", 64'(bus4.req_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
